// File: rtl/clock_turn_controller_if.sv
// Bundle between the chess-clock front end and its neighbours.
// Purpose: groups the board I/O / game-logic inputs and the clock-facing
// outputs of clock_turn_controller so they travel as one port.
// Signals:
//   btn_start, btn_turn : raw asynchronous pushbuttons, active-high
//   move_done           : one-cycle pulse when a legal move is committed
//   timeout[1:0]        : flag fell (bit0 white, bit1 black)
//   checkmate[1:0]      : side mated (bit0 white, bit1 black)
//   move                : one-cycle game-start pulse to the clock
//   turn                : side to move (0 white, 1 black)
//   game_over           : level, high once the game has ended
//   winner[1:0]         : 01 white, 10 black, 11 conflicting, 00 none
// Modports: master = board/game side, slave = controller.
interface clock_turn_controller_if;
  logic       btn_start;
  logic       btn_turn;
  logic       move_done;
  logic [1:0] timeout;
  logic [1:0] checkmate;
  logic       move;
  logic       turn;
  logic       game_over;
  logic [1:0] winner;

  modport master (
    output btn_start, btn_turn, move_done, timeout, checkmate,
    input  move, turn, game_over, winner
  );

  modport slave (
    input  btn_start, btn_turn, move_done, timeout, checkmate,
    output move, turn, game_over, winner
  );
endinterface

// File: rtl/clock_turn_controller.sv
// clock_turn_controller: chess-clock front end.
// Purpose: synchronises and debounces the start / end-of-turn buttons,
// issues the clock's start pulse, tracks the side to move, and latches the
// game-over condition with the winner.
// Ports:
//   clk   : system clock
//   reset : synchronous, active-high reset
//   bus   : clock_turn_controller_if.slave (buttons, move_done, timeout,
//           checkmate in; move, turn, game_over, winner out)
// Parameter: DEBOUNCE_CYCLES (>= 1) stable cycles before a button level
//            is accepted.
// Optional feature: define MOVE_DONE_TURN_EN to let move_done toggle the
// turn in addition to the end-of-turn button.

// Per-button conditioner: 2-flop synchroniser, debounced level, and a
// one-cycle event on each accepted rising level.
module ctc_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic evt
);
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic             level;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      level   <= 1'b0;
      cnt     <= '0;
      evt     <= 1'b0;
    end else begin
      // synchroniser stage boundary
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      // debounce stage boundary: any return to the accepted level restarts the count
      evt <= 1'b0;
      if (sync_p1 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync_p1;
        cnt   <= '0;
        evt   <= sync_p1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module clock_turn_controller #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic                    clk,
  input  logic                    reset,
  clock_turn_controller_if.slave  bus
);
  typedef enum logic [1:0] {S_WAIT, S_PLAYING, S_OVER} state_t;

  state_t     state_q;
  state_t     state_d;
  logic       move_d;
  logic       turn_d;
  logic       game_over_d;
  logic [1:0] winner_d;
  logic       start_evt;
  logic       btn_turn_evt;
  logic       turn_evt;
  logic       end_cond;

  ctc_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start_deb (
    .clk   (clk),
    .reset (reset),
    .raw   (bus.btn_start),
    .evt   (start_evt)
  );

  ctc_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_turn_deb (
    .clk   (clk),
    .reset (reset),
    .raw   (bus.btn_turn),
    .evt   (btn_turn_evt)
  );

`ifdef MOVE_DONE_TURN_EN
  assign turn_evt = btn_turn_evt | bus.move_done;
`else
  logic unused_move_done;
  assign unused_move_done = bus.move_done;
  assign turn_evt = btn_turn_evt;
`endif

  assign end_cond = (bus.checkmate != 2'b00) || (bus.timeout != 2'b00);

  // Checkmate outranks timeout; the mated/flagged side loses, 11 stays 11.
  function automatic logic [1:0] result(input logic [1:0] cm, input logic [1:0] to);
    logic [1:0] v;
    v = (cm != 2'b00) ? cm : to;
    case (v)
      2'b01:   result = 2'b10;
      2'b10:   result = 2'b01;
      2'b11:   result = 2'b11;
      default: result = 2'b00;
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    move_d      = 1'b0;
    turn_d      = bus.turn;
    game_over_d = bus.game_over;
    winner_d    = bus.winner;
    case (state_q)
      S_WAIT: begin
        turn_d = 1'b0;
        if (start_evt) begin
          move_d  = 1'b1;
          state_d = S_PLAYING;
        end
      end
      S_PLAYING: begin
        // the end of the game takes precedence over a simultaneous turn change
        if (end_cond) begin
          game_over_d = 1'b1;
          winner_d    = result(bus.checkmate, bus.timeout);
          state_d     = S_OVER;
        end else if (turn_evt) begin
          turn_d = ~bus.turn;
        end
      end
      S_OVER: begin
      end
      default: state_d = S_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_WAIT;
      bus.move      <= 1'b0;
      bus.turn      <= 1'b0;
      bus.game_over <= 1'b0;
      bus.winner    <= 2'b00;
    end else begin
      state_q       <= state_d;
      bus.move      <= move_d;
      bus.turn      <= turn_d;
      bus.game_over <= game_over_d;
      bus.winner    <= winner_d;
    end
  end
endmodule
